// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with start/ready handshake, returns {remainder, quotient}.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // state | meaning
    // IDLE  | waiting for start_i, outputs cleared
    // ON    | one restoring step per cycle, WIDTH steps total
    // END   | result valid, held until start_i drops
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [WIDTH-1:0]     rem, rem_n;
    logic [WIDTH-1:0]     quo, quo_n;
    logic [WIDTH-1:0]     dvsr, dvsr_n;
    logic                 neg_quo, neg_quo_n;
    logic                 neg_rem, neg_rem_n;
    logic [2*WIDTH-1:0]   result_n;
    logic                 ready_n;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       shifted;
    logic                 fits;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic [WIDTH-1:0]     rem_fix, quo_fix;

    // Operand magnitudes; in unsigned mode the raw values are the magnitudes.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // The shifted remainder needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1)
    // doubling the remainder can carry out of WIDTH bits.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvsr});
        rem_step = fits ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], fits};
        quo_fix  = neg_quo ? (~quo_step + 1'b1) : quo_step;
        rem_fix  = neg_rem ? (~rem_step + 1'b1) : rem_step;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem;
        quo_n     = quo;
        dvsr_n    = dvsr;
        neg_quo_n = neg_quo;
        neg_rem_n = neg_rem;
        result_n  = result_o;
        ready_n   = ready_o;

        case (state)
            S_IDLE: begin
                ready_n  = 1'b0;
                result_n = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = S_END;
                        ready_n = 1'b1;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag1 < mag2) begin
                        state_n  = S_END;
                        ready_n  = 1'b1;
                        result_n = {opdata1_i, {WIDTH{1'b0}}};
                    end
`endif
                    else begin
                        state_n   = S_ON;
                        cnt_n     = '0;
                        rem_n     = '0;
                        quo_n     = mag1;
                        dvsr_n    = mag2;
                        neg_quo_n = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_n = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            S_ON: begin
                if (annul_i || !start_i) begin
                    state_n  = S_IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else begin
                    rem_n = rem_step;
                    quo_n = quo_step;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_n  = S_END;
                        ready_n  = 1'b1;
                        result_n = {rem_fix, quo_fix};
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_n  = S_IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: begin
                state_n  = S_IDLE;
                ready_n  = 1'b0;
                result_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvsr     <= dvsr_n;
            neg_quo  <= neg_quo_n;
            neg_rem  <= neg_rem_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver pushes expected {result, ready cycle}, monitor pops on ready_o rise.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        int          when;
    } exp_t;
    exp_t sb[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, remainder carries dividend sign.
    function automatic logic [63:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
        longint q, r, sa, sb_;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb_ = longint'({32'd0, b});
        end
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(bit s, logic [31:0] a, logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? 32'(0 - a) : a;
        mb = (s && b[31]) ? 32'(0 - b) : b;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Monitor: compares on each rising ready_o.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: ready_o=1 with result %h, expected no result (cycle %0d)", result_o, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", result_o, e.res);
                    check("latency", 64'(cyc), 64'(e.when));
                end
            end
            prev = (ready_o === 1'b1);
        end
    end

    task automatic issue(bit s, logic [31:0] a, logic [31:0] b, int extra, bit push, output logic [63:0] r);
        exp_t e;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        r = ref_div(s, a, b);
        if (push) begin
            e.res  = r;
            e.when = cyc + extra + ref_lat(s, a, b);
            sb.push_back(e);
        end
    endtask

    // Waits for ready while scrambling operands, holds END briefly, then releases start.
    task automatic finish_div(logic [63:0] r);
        int n;
        int hold;
        n = 0;
        do begin
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
            n++;
        end while (ready_o !== 1'b1 && n < 100);
        if (ready_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready_o=%b expected 1 within %0d cycles", ready_o, n);
        end
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            annul_i = 1'($urandom);
            @(negedge clk);
            check("end_hold_ready", 64'(ready_o), 64'd1);
            check("end_hold_result", result_o, r);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    task automatic run_div(bit s, logic [31:0] a, logic [31:0] b);
        logic [63:0] r;
        issue(s, a, b, 0, 1'b1, r);
        finish_div(r);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] r;
        logic [31:0] a, b;
        bit          s;
        int          n;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'd3, 32'd10);
        run_div(1'b1, 32'd3, 32'd10);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);

        // Annul at cycle 10, start dropped in 11, new 9/3 from cycle 12.
        issue(1'b0, 32'd100, 32'd7, 0, 1'b0, r);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        run_div(1'b0, 32'd9, 32'd3);

        // Annul pulse with start held: divide restarts from cycle 11.
        issue(1'b0, 32'd100, 32'd7, 11, 1'b1, r);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        finish_div(r);

        // Annul together with start in IDLE: the start is ignored for that cycle.
        issue(1'b1, 32'hFFFF_FF00, 32'd3, 1, 1'b1, r);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        finish_div(r);

        // start_i dropped mid-divide: no result.
        issue(1'b0, 32'd50, 32'd5, 0, 1'b0, r);
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_ready", 64'(ready_o), 64'd0);

        // Reset at cycle 20 of a divide.
        issue(1'b0, 32'd1000, 32'd3, 0, 1'b0, r);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);

        // Reset while the result is being held in END.
        issue(1'b0, 32'd77, 32'd5, 0, 1'b1, r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_o !== 1'b1 && n < 100);
        check("end_ready_seen", 64'(ready_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: b = 32'd0;
                2: b = 32'($urandom_range(1, 15));
                3: begin
                    b = $urandom | 32'h0000_1000;
                    a = b >> $urandom_range(1, 8);
                end
                4: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h8000_0000;
                        1: a = 32'hFFFF_FFFF;
                        2: a = 32'd0;
                        default: a = 32'd1;
                    endcase
                    case ($urandom_range(0, 3))
                        0: b = 32'hFFFF_FFFF;
                        1: b = 32'd1;
                        2: b = 32'h8000_0000;
                        default: b = 32'h7FFF_FFFF;
                    endcase
                end
                default: b = b >> $urandom_range(0, 31);
            endcase
            run_div(s, a, b);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
